// File: rtl/reg_writeback_queue.sv
// Writeback queue sitting in front of a single register-file write port.
// Buffers results in order, drains one per unstalled cycle, and forwards pending values.
module reg_writeback_queue #(
  parameter int DATA_WIDTH_POW = 6,
  parameter int DATA_WIDTH     = 1 << DATA_WIDTH_POW,
  parameter int DEPTH          = 4
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       wbValid_in,
  output logic                       wbReady_out,
  input  logic [4:0]                 wbRd_in,
  input  logic [DATA_WIDTH-1:0]      wbData_in,
  input  logic                       stall_in,
  output logic                       regWrite_ctrl,
  output logic [4:0]                 rd_out,
  output logic [DATA_WIDTH-1:0]      writeData_out,
  input  logic [4:0]                 rs1_in,
  input  logic [4:0]                 rs2_in,
  output logic                       fwd1Hit_out,
  output logic                       fwd2Hit_out,
  output logic [DATA_WIDTH-1:0]      fwd1Data_out,
  output logic [DATA_WIDTH-1:0]      fwd2Data_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;
  } fwd_t;

  logic [4:0]            rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  push;
  logic                  pop;
  fwd_t                  fwd1;
  fwd_t                  fwd2;

  // Handshake: a request transfers when wbValid_in && wbReady_out at a rising edge;
  // ready depends only on registered occupancy, never on a same-cycle drain.
  assign wbReady_out = !reset && (count_out < CNT_W'(DEPTH));
  assign push        = wbValid_in && wbReady_out && (wbRd_in != 5'd0);
  assign pop         = !reset && (count_out != '0) && !stall_in;

  always_ff @(posedge clk_in) begin
    if (push) begin
      rd_mem[tail]   <= wbRd_in;
      data_mem[tail] <= wbData_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      count_out     <= '0;
      regWrite_ctrl <= 1'b0;
      rd_out        <= 5'd0;
      writeData_out <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head          <= head + PTR_W'(1);
        regWrite_ctrl <= 1'b1;
        rd_out        <= rd_mem[head];
        writeData_out <= data_mem[head];
      end else begin
        regWrite_ctrl <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_out <= count_out + CNT_W'(1);
        2'b01:   count_out <= count_out - CNT_W'(1);
        default: count_out <= count_out;
      endcase
    end
  end

  // Walk oldest to youngest so a younger match overrides; output stage is weakest.
  function automatic fwd_t lookup(input logic [4:0] rs);
    fwd_t             r;
    logic [PTR_W-1:0] idx;
    r = '0;
    if (regWrite_ctrl && (rd_out == rs)) begin
      r.hit  = 1'b1;
      r.data = writeData_out;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count_out) && (rd_mem[idx] == rs)) begin
        r.hit  = 1'b1;
        r.data = data_mem[idx];
      end
    end
    if ((rs == 5'd0) || reset) begin
      r = '0;
    end
    return r;
  endfunction

  always_comb begin
    fwd1 = lookup(rs1_in);
    fwd2 = lookup(rs2_in);
  end

  assign fwd1Hit_out  = fwd1.hit;
  assign fwd1Data_out = fwd1.data;
  assign fwd2Hit_out  = fwd2.hit;
  assign fwd2Data_out = fwd2.data;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios followed by randomized traffic,
// compared every cycle against a queue-based reference model and a write-order scoreboard.
module tb_reg_writeback_queue;

  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic          clk_in;
  logic          reset;
  logic          wbValid_in;
  logic          wbReady_out;
  logic [4:0]    wbRd_in;
  logic [DW-1:0] wbData_in;
  logic          stall_in;
  logic          regWrite_ctrl;
  logic [4:0]    rd_out;
  logic [DW-1:0] writeData_out;
  logic [4:0]    rs1_in;
  logic [4:0]    rs2_in;
  logic          fwd1Hit_out;
  logic          fwd2Hit_out;
  logic [DW-1:0] fwd1Data_out;
  logic [DW-1:0] fwd2Data_out;
  logic [2:0]    count_out;

  reg_writeback_queue #(.DATA_WIDTH_POW(6), .DEPTH(DEPTH)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .wbValid_in    (wbValid_in),
    .wbReady_out   (wbReady_out),
    .wbRd_in       (wbRd_in),
    .wbData_in     (wbData_in),
    .stall_in      (stall_in),
    .regWrite_ctrl (regWrite_ctrl),
    .rd_out        (rd_out),
    .writeData_out (writeData_out),
    .rs1_in        (rs1_in),
    .rs2_in        (rs2_in),
    .fwd1Hit_out   (fwd1Hit_out),
    .fwd2Hit_out   (fwd2Hit_out),
    .fwd1Data_out  (fwd1Data_out),
    .fwd2Data_out  (fwd2Data_out),
    .count_out     (count_out)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // reference model: pending entries oldest first, plus the write-port stage
  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic          m_wr;
  logic [4:0]    m_rd;
  logic [DW-1:0] m_wd;

  // scoreboard: accepted writes awaiting the write port, in acceptance order
  logic [DW+4:0] exp_q[$];
  logic [DW-1:0] wr_log[$];
  int            writes_seen;

  int checks;
  int failures;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_fwd(input logic [4:0] rs, output logic hit, output logic [DW-1:0] d);
    logic found;
    found = 1'b0;
    hit   = 1'b0;
    d     = '0;
    if (!reset && rs != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!found && mq[i].rd == rs) begin
          found = 1'b1;
          d     = mq[i].data;
        end
      end
      if (!found && m_wr && m_rd == rs) begin
        found = 1'b1;
        d     = m_wd;
      end
      hit = found;
    end
  endfunction

  task automatic compare_all();
    logic          h;
    logic [DW-1:0] d;
    logic [DW+4:0] e;
    check_eq("count", DW'(count_out), DW'(mq.size()));
    check_eq("ready", DW'(wbReady_out), DW'(!reset && mq.size() < DEPTH));
    check_eq("reg_write", DW'(regWrite_ctrl), DW'(m_wr));
    check_eq("rd_out", DW'(rd_out), DW'(m_rd));
    check_eq("write_data", writeData_out, m_wd);
    model_fwd(rs1_in, h, d);
    check_eq("fwd1_hit", DW'(fwd1Hit_out), DW'(h));
    check_eq("fwd1_data", fwd1Data_out, d);
    model_fwd(rs2_in, h, d);
    check_eq("fwd2_hit", DW'(fwd2Hit_out), DW'(h));
    check_eq("fwd2_data", fwd2Data_out, d);
    if (regWrite_ctrl === 1'b1) begin
      writes_seen++;
      wr_log.push_back(writeData_out);
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_write", DW'(1), DW'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_rd", DW'(rd_out), DW'(e[DW+4:DW]));
        check_eq("sb_data", writeData_out, e[DW-1:0]);
      end
    end
  endtask

  task automatic model_step();
    ent_t e;
    logic ready;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_wr = 1'b0;
      m_rd = 5'd0;
      m_wd = '0;
    end else begin
      ready = mq.size() < DEPTH;
      if (mq.size() > 0 && !stall_in) begin
        e    = mq.pop_front();
        m_wr = 1'b1;
        m_rd = e.rd;
        m_wd = e.data;
      end else begin
        m_wr = 1'b0;
      end
      if (wbValid_in && ready && wbRd_in != 5'd0) begin
        e.rd   = wbRd_in;
        e.data = wbData_in;
        mq.push_back(e);
        exp_q.push_back({wbRd_in, wbData_in});
      end
    end
  endtask

  // driver: apply one cycle of inputs, check state, clock it, advance the model
  task automatic tick(input logic a_rst, input logic a_v, input logic [4:0] a_rd,
                      input logic [DW-1:0] a_d, input logic a_st,
                      input logic [4:0] a_r1, input logic [4:0] a_r2);
    reset      = a_rst;
    wbValid_in = a_v;
    wbRd_in    = a_rd;
    wbData_in  = a_d;
    stall_in   = a_st;
    rs1_in     = a_r1;
    rs2_in     = a_r2;
    #1;
    compare_all();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  initial begin
    int base;
    checks      = 0;
    failures    = 0;
    writes_seen = 0;
    reset       = 1'b1;
    wbValid_in  = 1'b0;
    wbRd_in     = 5'd0;
    wbData_in   = '0;
    stall_in    = 1'b0;
    rs1_in      = 5'd0;
    rs2_in      = 5'd0;
    m_wr        = 1'b0;
    m_rd        = 5'd0;
    m_wd        = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);

    // reset state, with valid and stall ignored
    tick(1, 1, 5'd3, 64'h1234, 1, 5'd3, 5'd0);
    check_eq("rst_count", DW'(count_out), DW'(0));
    check_eq("rst_reg_write", DW'(regWrite_ctrl), DW'(0));
    tick(0, 0, 5'd0, '0, 0, 5'd0, 5'd0);

    // single write: accepted at edge N, on the write port after edge N+1
    tick(0, 1, 5'd5, 64'hDEAD, 0, 5'd5, 5'd0);
    tick(0, 0, 5'd0, '0, 0, 5'd5, 5'd0);
    check_eq("single_wr", DW'(regWrite_ctrl), DW'(1));
    check_eq("single_rd", DW'(rd_out), DW'(5));
    check_eq("single_data", writeData_out, 64'hDEAD);
    check_eq("single_fwd_hit", DW'(fwd1Hit_out), DW'(1));
    tick(0, 0, 5'd0, '0, 0, 5'd0, 5'd0);

    // zero register is accepted but dropped
    tick(0, 1, 5'd0, 64'hFFFF, 0, 5'd0, 5'd0);
    tick(0, 0, 5'd0, '0, 0, 5'd0, 5'd0);
    check_eq("zero_count", DW'(count_out), DW'(0));
    check_eq("zero_wr", DW'(regWrite_ctrl), DW'(0));
    check_eq("zero_fwd", DW'(fwd1Hit_out), DW'(0));

    // fill while stalled, then drain in order
    for (int i = 1; i <= 4; i++) tick(0, 1, 5'(i), DW'(i * 16), 1, 5'd0, 5'd0);
    tick(0, 1, 5'd9, 64'h99, 1, 5'd0, 5'd0);
    check_eq("full_count", DW'(count_out), DW'(4));
    check_eq("full_ready", DW'(wbReady_out), DW'(0));
    for (int i = 1; i <= 4; i++) begin
      tick(0, 0, 5'd0, '0, 0, 5'd0, 5'd0);
      check_eq("drain_wr", DW'(regWrite_ctrl), DW'(1));
      check_eq("drain_rd", DW'(rd_out), DW'(i));
    end
    check_eq("drain_count", DW'(count_out), DW'(0));
    tick(0, 0, 5'd0, '0, 0, 5'd0, 5'd0);

    // youngest pending value wins the forward
    tick(0, 1, 5'd7, 64'h11, 1, 5'd0, 5'd7);
    tick(0, 1, 5'd7, 64'h22, 1, 5'd0, 5'd7);
    tick(0, 0, 5'd0, '0, 1, 5'd0, 5'd7);
    check_eq("young_fwd_data", fwd2Data_out, 64'h22);
    tick(0, 0, 5'd0, '0, 0, 5'd0, 5'd7);
    check_eq("young_first", writeData_out, 64'h11);
    tick(0, 0, 5'd0, '0, 0, 5'd0, 5'd7);
    check_eq("young_second", writeData_out, 64'h22);
    tick(0, 0, 5'd0, '0, 0, 5'd0, 5'd0);

    // wrap-around stream of 3*DEPTH back-to-back requests
    wr_log.delete();
    base = writes_seen;
    for (int i = 0; i < 3 * DEPTH; i++) tick(0, 1, 5'((i % 7) + 1), DW'(i), 0, 5'(i % 8), 5'd1);
    repeat (3) tick(0, 0, 5'd0, '0, 0, 5'd0, 5'd0);
    check_eq("wrap_writes", DW'(writes_seen - base), DW'(3 * DEPTH));
    for (int i = 0; i < 3 * DEPTH && i < wr_log.size(); i++) check_eq("wrap_order", wr_log[i], DW'(i));

    // reset with three entries pending
    for (int i = 0; i < 3; i++) tick(0, 1, 5'(i + 10), DW'(64'hA0 + i), 1, 5'd10, 5'd0);
    tick(1, 1, 5'd12, 64'hBB, 0, 5'd10, 5'd11);
    tick(0, 0, 5'd0, '0, 0, 5'd10, 5'd0);
    check_eq("mid_rst_count", DW'(count_out), DW'(0));
    check_eq("mid_rst_wr", DW'(regWrite_ctrl), DW'(0));
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 5'd0, '0, 0, 5'd10, 5'd0);
      check_eq("mid_rst_stale", DW'(regWrite_ctrl), DW'(0));
    end

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      tick(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
           {$urandom, $urandom},
           ($urandom_range(0, 9) < 3),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end
    repeat (DEPTH + 2) tick(0, 0, 5'd0, '0, 0, 5'd0, 5'd0);
    check_eq("final_sb_empty", DW'(exp_q.size()), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
